// File: rtl/tmb_emu_pkg.sv
// Shared definitions for the test-pulse emulation blocks: sequencer state
// encoding and the default synchronizer depth.
package tmb_emu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous divider output and emits a registered one-cycle
// strobe per rising edge; legal SYNC_STAGES range is 2..4.
module sync_edge_detect
    import tmb_emu_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   r_rise;
    logic                   w_rise;

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_edge;

    // Strobe is registered so it is glitch-free and lands SYNC_STAGES+1 cycles after the input edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_edge <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_edge <= r_sync[SYNC_STAGES-1];
            r_rise <= w_rise;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/slow_tick_sequencer.sv
// Plays a burst of slow-period pulses aligned to synchronized slow_clock ticks.
// Optional macro SLOW_TICK_SEQUENCER_PULSE_COUNT_EN adds a saturating pulse_count output.
module slow_tick_sequencer
    import tmb_emu_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int BURST_W     = 8
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               slow_clock,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [BURST_W-1:0] gap_len,
    output logic               tick,
    output logic               pulse_out,
    output logic               busy,
    output logic               done
`ifdef SLOW_TICK_SEQUENCER_PULSE_COUNT_EN
    ,
    output logic [15:0]        pulse_count
`endif
);

    state_t             r_state;
    state_t             w_next;
    logic [BURST_W-1:0] r_rem;
    logic [BURST_W-1:0] r_gap;
    logic [BURST_W-1:0] r_gap_cnt;
    logic [BURST_W-1:0] w_rem_nxt;
    logic [BURST_W-1:0] w_gap_nxt;
    logic [BURST_W-1:0] w_gap_cnt_nxt;
    logic               w_zero_done;
    logic               w_tick;
    logic               r_pulse;
    logic               r_busy;
    logic               r_done;

    function automatic logic [BURST_W-1:0] gap_floor(input logic [BURST_W-1:0] g);
        return (g == '0) ? BURST_W'(1) : g;
    endfunction

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (clock_in),
        .i_rst_n(reset_n),
        .i_async(slow_clock),
        .o_rise (w_tick)
    );

    always_comb begin
        w_next        = r_state;
        w_rem_nxt     = r_rem;
        w_gap_nxt     = r_gap;
        w_gap_cnt_nxt = r_gap_cnt;
        w_zero_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        w_rem_nxt = burst_len;
                        w_gap_nxt = gap_floor(gap_len);
                        w_next    = ST_ARM;
                    end else begin
                        w_zero_done = 1'b1;
                    end
                end
            end
            ST_ARM: begin
                if (w_tick) begin
                    w_rem_nxt = r_rem - 1'b1;
                    w_next    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_tick) begin
                    if (r_rem == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_gap_cnt_nxt = r_gap - 1'b1;
                        w_next        = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    if (r_gap_cnt == '0) begin
                        w_rem_nxt = r_rem - 1'b1;
                        w_next    = ST_PULSE;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                    end
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rem     <= w_rem_nxt;
            r_gap     <= w_gap_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_pulse   <= (w_next == ST_PULSE);
            r_busy    <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_DONE) | w_zero_done;
        end
    end

    assign tick      = w_tick;
    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef SLOW_TICK_SEQUENCER_PULSE_COUNT_EN
    logic [15:0] r_pulse_count;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_count <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_pulse_count <= '0;
        end else if (w_next == ST_PULSE && r_state != ST_PULSE) begin
            r_pulse_count <= sat_inc16(r_pulse_count);
        end
    end

    assign pulse_count = r_pulse_count;
`endif

endmodule

// File: tb/tb_slow_tick_sequencer.sv
// Directed bench for slow_tick_sequencer with a divide-by-8 slow_clock source.
module tb_slow_tick_sequencer;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] burst_len;
    logic [7:0] gap_len;
    logic       tick;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [2:0] div_cnt = 3'd0;
    logic       slow_clock;
`ifdef SLOW_TICK_SEQUENCER_PULSE_COUNT_EN
    logic [15:0] pulse_count;
`endif

    int checks = 0;
    int errors = 0;

    bit tr_pulse [0:199];
    bit tr_busy  [0:199];
    bit tr_done  [0:199];
    bit tr_tick  [0:199];

    always #5 clock_in = ~clock_in;

    // Upstream divider model: slow_clock changes just after a clock_in rising edge.
    always @(posedge clock_in) div_cnt <= div_cnt + 3'd1;
    assign slow_clock = div_cnt[2];

    slow_tick_sequencer dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .slow_clock(slow_clock),
        .start     (start),
        .burst_len (burst_len),
        .gap_len   (gap_len),
        .tick      (tick),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
`ifdef SLOW_TICK_SEQUENCER_PULSE_COUNT_EN
        ,
        .pulse_count(pulse_count)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic do_start(input logic [7:0] bl, input logic [7:0] gl);
        burst_len = bl;
        gap_len   = gl;
        start     = 1'b1;
        @(negedge clock_in);
        start     = 1'b0;
    endtask

    // Samples n negedges; at index start_at a competing start (len 7, gap 0) is pulsed.
    task automatic capture(input int n, input int start_at);
        for (int i = 0; i < n; i++) begin
            tr_pulse[i] = pulse_out;
            tr_busy[i]  = busy;
            tr_done[i]  = done;
            tr_tick[i]  = tick;
            if (i == start_at) begin
                start     = 1'b1;
                burst_len = 8'd7;
                gap_len   = 8'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clock_in);
        end
        start = 1'b0;
    endtask

    task automatic analyze(input string tag, input int n, input int exp_pulses,
                           input int exp_hi, input int exp_lo);
        int rises, hi_len, lo_len, dcnt, d;
        bit seen_hi, prev;
        rises = 0; hi_len = 0; lo_len = 0; dcnt = 0; d = -1;
        seen_hi = 0; prev = 0;
        chk({tag, "_busy_after_start"}, tr_busy[0], 1);
        chk({tag, "_pulse_low_at_start"}, tr_pulse[0], 0);
        for (int i = 0; i < n; i++) begin
            if (tr_pulse[i]) begin
                if (!prev) begin
                    rises++;
                    if (i > 0) chk({tag, "_rise_follows_tick"}, tr_tick[i-1], 1);
                    if (seen_hi) chk({tag, "_gap_len"}, lo_len, exp_lo);
                end
                hi_len++;
                lo_len  = 0;
                seen_hi = 1;
            end else begin
                if (hi_len > 0) chk({tag, "_pulse_len"}, hi_len, exp_hi);
                hi_len = 0;
                lo_len++;
            end
            if (tr_done[i]) begin
                dcnt++;
                if (d < 0) d = i;
            end
            prev = tr_pulse[i];
        end
        chk({tag, "_pulse_count"}, rises, exp_pulses);
        chk({tag, "_done_count"}, dcnt, 1);
        if (d > 0 && d < n - 1) begin
            chk({tag, "_done_after_tick"}, tr_tick[d-1], 1);
            chk({tag, "_done_after_last_pulse"}, tr_pulse[d-1], 1);
            chk({tag, "_busy_with_done"}, tr_busy[d], 1);
            chk({tag, "_busy_falls"}, tr_busy[d+1], 0);
        end
    endtask

    initial begin
        int found, nt, s_done, s_busy, s_pulse, rises;
        bit prev;
        reset_n   = 1'b0;
        start     = 1'b0;
        burst_len = 8'd0;
        gap_len   = 8'd0;

        // Reset state
        step(3);
        chk("rst_tick", tick, 0);
        chk("rst_pulse", pulse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset_n = 1'b1;
        step(4);

        // Tick latency and period
        found = 0;
        prev  = slow_clock;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clock_in);
            if (!prev && slow_clock) found = 1;
            prev = slow_clock;
        end
        chk("slow_rise_seen", found, 1);
        step(1); chk("tick_lat_1", tick, 0);
        step(1); chk("tick_lat_2", tick, 0);
        step(1); chk("tick_lat_3", tick, 1);
        step(1); chk("tick_width", tick, 0);
        nt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock_in);
            nt += int'(tick);
        end
        chk("tick_count_32", nt, 4);

        // Burst of 3, gap 2
        do_start(8'd3, 8'd2);
        capture(120, -1);
        analyze("b3g2", 120, 3, 8, 16);

        // Zero-length burst
        do_start(8'd0, 8'd5);
        capture(30, -1);
        s_done = 0; s_busy = 0; s_pulse = 0;
        for (int i = 0; i < 30; i++) begin
            s_done  += int'(tr_done[i]);
            s_busy  += int'(tr_busy[i]);
            s_pulse += int'(tr_pulse[i]);
        end
        chk("b0_done_first", tr_done[0], 1);
        chk("b0_done_once", s_done, 1);
        chk("b0_busy_never", s_busy, 0);
        chk("b0_pulse_never", s_pulse, 0);

        // Gap 0 treated as 1; start during busy ignored
        do_start(8'd2, 8'd0);
        capture(100, 20);
        analyze("b2g0", 100, 2, 8, 8);

        // Reset in the middle of the second pulse
        do_start(8'd3, 8'd2);
        rises = 0;
        prev  = 0;
        for (int i = 0; i < 120 && rises < 2; i++) begin
            @(negedge clock_in);
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
        end
        chk("rst_mid_second_pulse_seen", rises, 2);
        step(3);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_pulse", pulse_out, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_tick", tick, 0);
        step(3);
        reset_n = 1'b1;
        step(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_pulse", pulse_out, 0);
        do_start(8'd1, 8'd1);
        capture(60, -1);
        analyze("post_rst_b1", 60, 1, 8, 0);

`ifdef SLOW_TICK_SEQUENCER_PULSE_COUNT_EN
        do_start(8'd5, 8'd1);
        capture(120, -1);
        analyze("pc_b5g1", 120, 5, 8, 8);
        chk("pc_after_b5", pulse_count, 5);
        do_start(8'd2, 8'd1);
        chk("pc_cleared_on_start", pulse_count, 0);
        capture(60, -1);
        chk("pc_after_b2", pulse_count, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slow_tick_sequencer.md
Name: slow_tick_sequencer

Overview:
- Sits directly downstream of the clock divider and consumes its divided output (`slow_clock`), sampled in the fast `clock_in` domain.
- Synchronizes `slow_clock` and turns each of its rising edges into a one-cycle `tick`.
- Uses those ticks to play a programmable burst of pulses (N pulses, each one slow period wide, separated by a programmable gap) with a `start`/`busy`/`done` handshake.
- Used for LED blink patterns and emulated test-pulse trains.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `slow_clock`; legal values 2..4.
- BURST_W, 8, width of the `burst_len` and `gap_len` fields and their internal counters.

Ports:
- clock_in  input  1  fast system clock, the same clock that drives the divider.
- reset_n  input  1  asynchronous active-low reset.
- slow_clock  input  1  divided clock from clock_divider; treated as asynchronous data.
- start  input  1  request to begin a burst; sampled only in IDLE.
- burst_len  input  BURST_W  number of pulses in the burst; sampled on an accepted start.
- gap_len  input  BURST_W  low time between pulses, in ticks; sampled on an accepted start.
- tick  output  1  one-cycle strobe per synchronized rising edge of `slow_clock`.
- pulse_out  output  1  the pulse train.
- busy  output  1  high from an accepted start until `done`.
- done  output  1  one-cycle strobe when a burst completes.

Behaviour:
- Reset: asynchronous, active-low. While reset_n=0 the sync chain, edge register, counters and all outputs are 0, and the FSM is in IDLE. Deasserting reset mid-burst leaves the block idle.
- Synchronizer: SYNC_STAGES flops, then one edge register.
  - tick = sync_last & ~edge_reg.
  - Latency: tick asserts SYNC_STAGES+1 clock_in cycles after slow_clock rises.
  - Falling edges are ignored.
  - tick runs in every FSM state.
- FSM states: IDLE, ARM, PULSE, GAP, DONE.
- IDLE:
  - busy=0 and pulse_out=0.
  - start=1 with burst_len!=0: latch remaining=burst_len and gap=max(gap_len,1), then go to ARM.
  - start=1 with burst_len==0: done=1 for one cycle, busy stays 0, stay in IDLE.
- ARM:
  - busy=1.
  - Wait for tick. On tick go to PULSE and decrement remaining.
  - Purpose: pulse edges align to ticks; a partial slow period is never emitted.
- PULSE:
  - pulse_out=1 and busy=1.
  - On tick:
    - if remaining==0, go to DONE;
    - else load gap_cnt=gap-1 and go to GAP.
- GAP:
  - pulse_out=0.
  - On tick:
    - if gap_cnt==0, go to PULSE and decrement remaining;
    - else decrement gap_cnt.
- DONE: done=1 and busy=1 for one cycle, then go to IDLE. busy falls the cycle after done.
- pulse_out is registered. It rises the cycle after the entering tick and falls the cycle after the leaving tick, so each pulse is exactly one slow period, and each gap is exactly `gap` slow periods.
- start while busy is ignored; it is not queued.
- Inputs are captured only on an accepted start. Changes to burst_len/gap_len mid-burst have no effect.
- A tick arriving on the same cycle as an accepted start is not counted; ARM waits for the next tick.
- All counters are unsigned BURST_W bits. burst_len=2^BURST_W-1 is legal, and no counter wraps.

Optional Feature:
- Macro: SLOW_TICK_SEQUENCER_PULSE_COUNT_EN.
- When defined:
  - Adds output `pulse_count` [15:0], a free-running count of pulse_out rising edges.
  - The count saturates at 16'hFFFF.
  - Cleared by reset and by each accepted start.
- When undefined: the port and the counter do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package `tmb_emu_pkg`: FSM state encoding constants (IDLE=0, ARM=1, PULSE=2, GAP=3, DONE=4) and the default SYNC_STAGES.
- One sub-module, `sync_edge_detect`: the synchronizer chain plus rising-edge strobe, parameterized by SYNC_STAGES. It is reusable for other divider-fed inputs.

Test Plan:
- slow_clock = clock_in/8 (50% duty), SYNC_STAGES=2, idle → tick pulses once every 8 cycles, each pulse is one cycle wide, and the first tick comes exactly 3 cycles after the slow_clock rise.
- start with burst_len=3, gap_len=2 → three pulse_out highs, each 8 cycles, separated by 16-cycle lows. done fires once, 1 cycle after the tick ending the third pulse, and busy falls the following cycle.
- start with burst_len=0 → done for 1 cycle, busy never rises, pulse_out stays 0.
- gap_len=0, burst_len=2 → gap is treated as 1: an 8-cycle low between the two 8-cycle pulses. Pulling start high again during busy → no effect.
- reset_n pulled low in the middle of the second pulse → pulse_out, busy, done and tick go to 0 immediately. After release the FSM is IDLE and a new start works normally.
- With SLOW_TICK_SEQUENCER_PULSE_COUNT_EN defined: run burst_len=5 → pulse_count=5. A new start resets it to 0 before the first pulse.
